display_scan_driver: RTL

- Time-multiplexed scan controller that produces the 4-bit character code consumed by the 7-segment DisplayDecoder, plus active-low digit enables.
- Holds one frame of NUM_DIGITS character codes, double-buffered behind a valid/ready load port.
- Cycles through the digits with a blanking gap between them, and commits newly loaded frames only at frame boundaries, so a displayed frame never tears.

---
 rtl/display_scan_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - time-multiplexed 7-segment scan driver with a double-buffered frame load port
module display_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter logic [3:0]  BLANK_CODE   = 4'd15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  output logic [3:0]                    char_sel,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0][3:0]     display_q, display_d;
  logic [NUM_DIGITS-1:0][3:0]     pending_q, pending_d;
  logic                           pending_valid_q, pending_valid_d;
  logic                           load_ready_q, load_ready_d;
  logic [3:0]                     char_sel_q, char_sel_d;
  logic [NUM_DIGITS-1:0]          an_n_q, an_n_d;
  logic                           frame_done_q, frame_done_d;
  logic                           load_fire;
  logic                           commit;

  // Next-state: scan sequencing, frame-boundary commit, load capture and registered output values
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    digit_idx_d     = digit_idx_q;
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_done_d    = 1'b0;
    commit          = 1'b0;
    load_fire       = load_valid && load_ready_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        digit_idx_d = '0;
        if (enable) begin
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          digit_idx_d = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          // Stopping never counts as a frame boundary, so pending stays put
          state_d     = ST_IDLE;
          cnt_d       = '0;
          digit_idx_d = '0;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (digit_idx_q == IDX_LAST) begin
            digit_idx_d  = '0;
            frame_done_d = 1'b1;
            commit       = pending_valid_q;
          end else begin
            digit_idx_d = digit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        digit_idx_d = '0;
      end
    endcase

    if (commit) begin
      display_d       = pending_q;
      pending_valid_d = 1'b0;
    end

    // A commit and a load never coincide: pending is full whenever commit is set, so ready is low
    if (load_fire) begin
      if (state_q == ST_IDLE) begin
        display_d = load_data;
      end else begin
        pending_d       = load_data;
        pending_valid_d = 1'b1;
      end
    end

    // Ready reopens one cycle after the commit, not in the boundary cycle itself
    load_ready_d = !pending_valid_d && !commit;

    // Outputs follow the next state so they line up with it cycle for cycle
    char_sel_d = (state_d == ST_IDLE) ? BLANK_CODE : display_d[digit_idx_d];
    an_n_d     = '1;
    if (state_d == ST_SHOW) begin
      an_n_d[digit_idx_d] = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      digit_idx_q     <= '0;
      display_q       <= {NUM_DIGITS{BLANK_CODE}};
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      load_ready_q    <= 1'b1;
      char_sel_q      <= BLANK_CODE;
      an_n_q          <= '1;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      digit_idx_q     <= digit_idx_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      load_ready_q    <= load_ready_d;
      char_sel_q      <= char_sel_d;
      an_n_q          <= an_n_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign char_sel   = char_sel_q;
  assign an_n       = an_n_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule
